// File: rtl/wts_pkg.sv
// Shared types and constants for the wave-table channel scheduler.
// The FSM states and datapath widths live here so the top and the multiplier agree.
package wts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ACC,
        DONE
    } state_t;

    localparam int WAVE_PTR_W = 5;
    localparam int SAMPLE_W   = 8;
    localparam int VOLUME_W   = 4;
    localparam int VOL_SHIFT  = 4;

endpackage

// File: rtl/wts_volume_mul.sv
// Shared volume stage: one signed sample times an unsigned 4-bit volume, scaled by 1/16.
// The scaled result is registered on i_load and forced to zero for disabled channels.
module wts_volume_mul
    import wts_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic                       i_enable,
    input  logic [SAMPLE_W-1:0]        i_sample,
    input  logic [VOLUME_W-1:0]        i_volume,
    output logic signed [SAMPLE_W-1:0] o_contrib
);

    localparam int PROD_W = SAMPLE_W + VOLUME_W;

    logic signed [PROD_W-1:0]   w_sample_ext;
    logic signed [PROD_W-1:0]   w_volume_ext;
    logic signed [PROD_W-1:0]   w_product;
    logic signed [SAMPLE_W-1:0] w_scaled;
    logic signed [SAMPLE_W-1:0] r_contrib;

    // The volume is zero-extended so it behaves as a non-negative signed factor.
    assign w_sample_ext = PROD_W'($signed(i_sample));
    assign w_volume_ext = $signed({{(PROD_W-VOLUME_W){1'b0}}, i_volume});
    assign w_product    = w_sample_ext * w_volume_ext;
    assign w_scaled     = SAMPLE_W'(w_product >>> VOL_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_contrib <= '0;
        end else if (i_load) begin
            r_contrib <= i_enable ? w_scaled : '0;
        end
    end

    assign o_contrib = r_contrib;

endmodule

// File: rtl/wts_channel_scheduler.sv
// Time-slot scheduler: walks every wave channel once per sample tick through one SRAM port
// and one volume multiplier, accumulating a signed mix and owning the per-channel wave pointers.
module wts_channel_scheduler
    import wts_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int MIX_W    = 8 + $clog2(CHANNELS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   sample_tick,
    input  logic [CHANNELS-1:0]                    step_req,
    input  logic [CHANNELS-1:0]                    ch_enable,
    input  logic [VOLUME_W*CHANNELS-1:0]           reg_volume,
    output logic [$clog2(CHANNELS)+WAVE_PTR_W-1:0] sram_address,
    output logic                                   sram_rd,
    input  logic [SAMPLE_W-1:0]                    sram_q,
    output logic signed [MIX_W-1:0]                mix_out,
    output logic                                   mix_valid,
    output logic                                   overrun
);

    localparam int CH_W   = $clog2(CHANNELS);
    localparam int ADDR_W = CH_W + WAVE_PTR_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CH_W-1:0]         r_ch;
    logic [CH_W-1:0]         w_next_ch;
    logic                    w_start;

    logic [WAVE_PTR_W-1:0]   r_ptr      [CHANNELS];
    logic [WAVE_PTR_W-1:0]   w_ptr_next [CHANNELS];
    logic [ADDR_W-1:0]       w_addr_next;

    logic [VOLUME_W-1:0]     r_vol [CHANNELS];
    logic [CHANNELS-1:0]     r_en;

    logic signed [MIX_W-1:0]    r_acc;
    logic signed [MIX_W-1:0]    r_mix_out;
    logic                       r_mix_valid;
    logic                       r_sram_rd;
    logic [ADDR_W-1:0]          r_sram_address;
    logic                       r_overrun;
    logic signed [SAMPLE_W-1:0] w_contrib;
    logic signed [MIX_W-1:0]    w_contrib_ext;

    always_comb begin
        w_next_state = r_state;
        w_next_ch    = r_ch;
        case (r_state)
            IDLE: begin
                if (sample_tick) begin
                    w_next_state = ADDR;
                    w_next_ch    = '0;
                end
            end
            ADDR: w_next_state = DATA;
            DATA: w_next_state = ACC;
            ACC: begin
                if (r_ch == LAST_CH) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = ADDR;
                    w_next_ch    = r_ch + CH_W'(1);
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_next_state;
            r_ch    <= w_next_ch;
        end
    end

    assign w_start = (r_state == IDLE) && sample_tick;

    // Address is registered on entry to ADDR from the post-step pointer, so a step in the
    // ADDR cycle itself only shows up in the next frame.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_ptr_next[n] = r_ptr[n] + {{(WAVE_PTR_W-1){1'b0}}, step_req[n]};
        end
        w_addr_next = {w_next_ch, w_ptr_next[w_next_ch]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_ptr[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_ptr[n] <= w_ptr_next[n];
            end
        end
    end

    wts_volume_mul u_volume_mul (
        .clk       (clk),
        .reset     (reset),
        .i_load    (r_state == DATA),
        .i_enable  (r_en[r_ch]),
        .i_sample  (sram_q),
        .i_volume  (r_vol[r_ch]),
        .o_contrib (w_contrib)
    );

    assign w_contrib_ext = MIX_W'(w_contrib);

    // Frame snapshot, accumulator and registered outputs; the last slot's sum goes straight
    // to mix_out so it lines up with the mix_valid pulse in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_vol[n] <= '0;
            end
            r_en           <= '0;
            r_acc          <= '0;
            r_mix_out      <= '0;
            r_mix_valid    <= 1'b0;
            r_sram_rd      <= 1'b0;
            r_sram_address <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_sram_rd   <= (w_next_state == ADDR);
            r_mix_valid <= (w_next_state == DONE);
            r_overrun   <= sample_tick && (r_state != IDLE);
            if (w_next_state == ADDR) begin
                r_sram_address <= w_addr_next;
            end
            if (w_start) begin
                r_acc <= '0;
                r_en  <= ch_enable;
                for (int n = 0; n < CHANNELS; n++) begin
                    r_vol[n] <= reg_volume[VOLUME_W*n +: VOLUME_W];
                end
            end else if (r_state == ACC) begin
                r_acc <= r_acc + w_contrib_ext;
                if (r_ch == LAST_CH) begin
                    r_mix_out <= r_acc + w_contrib_ext;
                end
            end
        end
    end

    assign sram_address = r_sram_address;
    assign sram_rd      = r_sram_rd;
    assign mix_out      = r_mix_out;
    assign mix_valid    = r_mix_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Self-checking bench for wts_channel_scheduler: directed corner frames plus random frames,
// each compared against a frame-level model of pointers, SRAM contents and volume scaling.
module tb_wts_channel_scheduler;

    localparam int CHANNELS = 5;
    localparam int MIX_W    = 11;
    localparam int ADDR_W   = 8;
    localparam int FRAME_LATENCY = 3 * CHANNELS + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    sample_tick;
    logic [CHANNELS-1:0]     step_req;
    logic [CHANNELS-1:0]     ch_enable;
    logic [4*CHANNELS-1:0]   reg_volume;
    logic [ADDR_W-1:0]       sram_address;
    logic                    sram_rd;
    logic [7:0]              sram_q;
    logic signed [MIX_W-1:0] mix_out;
    logic                    mix_valid;
    logic                    overrun;

    logic [7:0]        mem [256];
    int                modelPtr [CHANNELS];
    int                assertCount = 0;
    int                failCount   = 0;
    logic              rdLatched;
    logic [ADDR_W-1:0] addrLatched;

    always #5 clk = ~clk;

    wts_channel_scheduler #(
        .CHANNELS (CHANNELS),
        .MIX_W    (MIX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .step_req     (step_req),
        .ch_enable    (ch_enable),
        .reg_volume   (reg_volume),
        .sram_address (sram_address),
        .sram_rd      (sram_rd),
        .sram_q       (sram_q),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .overrun      (overrun)
    );

    // SRAM with one-cycle read latency; outside the data cycle it returns noise.
    always @(posedge clk) begin
        rdLatched   = sram_rd;
        addrLatched = sram_address;
        #1;
        sram_q = rdLatched ? mem[addrLatched] : 8'($urandom);
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int floorDiv16(input int p);
        int q;
        q = p / 16;
        if ((p % 16 != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    // Pointer a channel sees in its read slot; a step landing no later than the cycle that
    // enters that slot (cycle 3n after the tick) is already visible.
    function automatic int ptrAtSlot(input int n, input int stepAt);
        int bump;
        bump = (stepAt > 0 && n == 2 && stepAt <= 3 * n) ? 1 : 0;
        return (modelPtr[n] + bump) % 32;
    endfunction

    function automatic int expectedMix(input int stepAt);
        int sum;
        int s;
        int v;
        sum = 0;
        for (int n = 0; n < CHANNELS; n++) begin
            s = int'($signed(mem[n * 32 + ptrAtSlot(n, stepAt)]));
            v = int'(reg_volume[4*n +: 4]);
            if (ch_enable[n]) sum += floorDiv16(s * v);
        end
        return sum;
    endfunction

    task automatic fillMem(input int mode);
        for (int a = 0; a < 256; a++) begin
            case (mode)
                0:       mem[a] = 8'h7F;
                1:       mem[a] = 8'h80;
                default: mem[a] = 8'($urandom);
            endcase
        end
    endtask

    task automatic stepPulses(input logic [CHANNELS-1:0] mask, input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            step_req = mask;
            for (int n = 0; n < CHANNELS; n++) begin
                if (mask[n]) modelPtr[n] = (modelPtr[n] + 1) % 32;
            end
        end
        @(negedge clk);
        step_req = '0;
    endtask

    // One frame: tick, optional mid-frame register change / extra tick / ch2 step, then
    // check every read address, latency, mix value and overrun count.
    task automatic applyStimulus(input string name, input int volChangeAt,
                                 input int extraTickAt, input int stepAt);
        int expAddr [CHANNELS];
        int expMix;
        int rdCount;
        int ovCount;
        int validAt;
        int mixObs;
        @(negedge clk);
        for (int n = 0; n < CHANNELS; n++) expAddr[n] = n * 32 + ptrAtSlot(n, stepAt);
        expMix      = expectedMix(stepAt);
        sample_tick = 1'b1;
        rdCount = 0;
        ovCount = 0;
        validAt = 0;
        mixObs  = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            sample_tick = (cyc == extraTickAt);
            step_req    = (cyc == stepAt) ? 5'b00100 : 5'b00000;
            if (cyc == volChangeAt) begin
                reg_volume = 20'($urandom);
                ch_enable  = 5'($urandom);
            end
            if (sram_rd) begin
                if (rdCount < CHANNELS)
                    checkOutput($sformatf("%s addr ch%0d", name, rdCount),
                                int'(sram_address), expAddr[rdCount]);
                rdCount++;
            end
            if (overrun) ovCount++;
            if (mix_valid) begin
                validAt = cyc;
                mixObs  = int'(mix_out);
                break;
            end
        end
        if (extraTickAt > 0 && extraTickAt >= validAt) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (overrun) ovCount++;
            checkOutput({name, " validPulse"}, int'(mix_valid), 0);
        end
        checkOutput({name, " latency"}, validAt, FRAME_LATENCY);
        checkOutput({name, " mix"}, mixObs, expMix);
        checkOutput({name, " reads"}, rdCount, CHANNELS);
        checkOutput({name, " overrun"}, ovCount, (extraTickAt > 0) ? 1 : 0);
        if (stepAt > 0) modelPtr[2] = (modelPtr[2] + 1) % 32;
    endtask

    task automatic midFrameReset(input int resetAt);
        int validCount;
        int rdCount;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int cyc = 1; cyc <= resetAt; cyc++) begin
            @(negedge clk);
            sample_tick = 1'b0;
        end
        reset = 1'b1;
        #1;
        checkOutput("abort mix_out", int'(mix_out), 0);
        checkOutput("abort mix_valid", int'(mix_valid), 0);
        checkOutput("abort sram_rd", int'(sram_rd), 0);
        checkOutput("abort sram_address", int'(sram_address), 0);
        checkOutput("abort overrun", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < CHANNELS; n++) modelPtr[n] = 0;
        validCount = 0;
        rdCount    = 0;
        repeat (20) begin
            @(negedge clk);
            if (mix_valid) validCount++;
            if (sram_rd) rdCount++;
        end
        checkOutput("abort no valid", validCount, 0);
        checkOutput("abort no reads", rdCount, 0);
    endtask

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b0;
        step_req    = '0;
        ch_enable   = '0;
        reg_volume  = '0;
        sram_q      = '0;
        for (int n = 0; n < CHANNELS; n++) modelPtr[n] = 0;
        fillMem(0);
        repeat (3) @(negedge clk);
        checkOutput("reset mix_out", int'(mix_out), 0);
        checkOutput("reset mix_valid", int'(mix_valid), 0);
        checkOutput("reset sram_rd", int'(sram_rd), 0);
        checkOutput("reset sram_address", int'(sram_address), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        reset = 1'b0;

        ch_enable  = 5'b11111;
        reg_volume = '0;
        applyStimulus("zeroVol", 0, 0, 0);

        ch_enable  = 5'b00001;
        reg_volume = '1;
        applyStimulus("ch0Max", 0, 0, 0);
        fillMem(1);
        applyStimulus("ch0Min", 0, 0, 0);

        ch_enable = 5'b11111;
        applyStimulus("allMin", 0, 0, 0);
        fillMem(0);
        applyStimulus("allMax", 0, 0, 0);

        fillMem(2);
        reg_volume = 20'($urandom);
        stepPulses(5'b00100, 33);
        applyStimulus("ptrWrap", 0, 0, 0);
        applyStimulus("stepInAddr", 0, 0, 7);
        applyStimulus("stepSettled", 0, 0, 0);
        applyStimulus("stepBeforeAddr", 0, 0, 6);

        applyStimulus("tickMidFrame", 0, 5, 0);
        applyStimulus("tickInDone", 0, 16, 0);
        applyStimulus("afterOverrun", 0, 0, 0);

        applyStimulus("volChange", 3, 0, 0);

        for (int f = 0; f < 20; f++) begin
            fillMem(2);
            reg_volume = 20'($urandom);
            ch_enable  = 5'($urandom);
            stepPulses(5'($urandom_range(0, 31)), $urandom_range(0, 3));
            applyStimulus($sformatf("rand%0d", f), 0, 0, 0);
        end

        stepPulses(5'b11111, 3);
        midFrameReset(8);
        fillMem(2);
        ch_enable  = 5'b11111;
        reg_volume = 20'($urandom);
        applyStimulus("afterReset", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/wts_channel_scheduler.md
# wts_channel_scheduler

Time-slot scheduler that shares one wave-memory read port and one volume-scaling datapath among all wave-table channels. On each sample tick it walks the channels in order, reads each channel's current wave sample from the shared SRAM, and scales it by that channel's 4-bit volume. It accumulates the scaled values into a single signed mix sample with a valid strobe. It sits between the register file and tone generators upstream and the output DAC/filter downstream, and it owns the per-channel 5-bit wave pointers.

## Interface
Parameters:
- CHANNELS, 5, number of wave channels (2..8)
- MIX_W, 8+$clog2(CHANNELS), width of mix output (11 for 5 channels)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset; one clock domain only
- sample_tick  in  1  one-cycle pulse that starts a frame
- step_req  in  CHANNELS  per-channel pulse; advances that channel's wave pointer by 1
- ch_enable  in  CHANNELS  per-channel enable; disabled channels contribute 0
- reg_volume  in  4*CHANNELS  per-channel unsigned volume, channel n at [4n+3:4n]
- sram_address  out  $clog2(CHANNELS)+5  {channel, pointer}
- sram_rd  out  1  read strobe, 1-cycle read latency
- sram_q  in  8  signed wave sample, valid the cycle after sram_rd
- mix_out  out  MIX_W  signed mixed sample, held until the next frame completes
- mix_valid  out  1  one-cycle pulse when mix_out updates
- overrun  out  1  one-cycle pulse when sample_tick arrives while busy

## Operation
- FSM states: IDLE, ADDR, DATA, ACC, DONE.
- IDLE to ADDR on sample_tick:
  - Clear accumulator, set ch=0.
  - Snapshot reg_volume and ch_enable into frame registers. Changes mid-frame take effect next frame.
- ADDR: drive sram_address={ch, ptr[ch]}, sram_rd=1, then go to DATA.
- DATA: register product = sram_q (signed 8) × {1'b0, vol[ch]} (signed 5), giving a 12-bit signed result. Go to ACC.
- ACC:
  - Add contribution to the accumulator: product >>> 4 (arithmetic, floor) if enabled, else 0.
  - If ch==CHANNELS-1, go to DONE; otherwise ch+1 and go to ADDR.
- DONE: mix_out <= accumulator, mix_valid=1, go to IDLE.
- Disabled channels still occupy their slot and still read SRAM, so frame length is fixed.
- Pointers:
  - ptr[n] increments mod 32 on step_req[n] in any state.
  - step_req coincident with that channel's ADDR cycle: the address uses the pre-increment value.
- sample_tick in any state other than IDLE: ignored, overrun pulses the next cycle, and the frame in progress is unaffected.
- A sample_tick in the DONE cycle counts as overrun.
- Arithmetic range: the accumulator is MIX_W signed and cannot overflow (per channel -120..119). No saturation logic.

## Timing
- Reset values:
  - State IDLE, ch=0, all ptr=0, accumulator=0.
  - mix_out=0, mix_valid=0, sram_rd=0, sram_address=0, overrun=0.
- Reset asserted mid-frame aborts immediately and no mix_valid is produced.
- Tick sampled at edge k: ADDR for channel 0 is the cycle after k. mix_valid is high in cycle k+3*CHANNELS+1 (k+16 for 5 channels).
- Minimum tick spacing without overrun: 3*CHANNELS+2 cycles.
- sram_rd is high exactly in ADDR cycles, CHANNELS pulses per frame. sram_q is sampled only in DATA.
- All outputs are registered.

## Structure
- Shared package wts_pkg holds:
  - state enum (IDLE, ADDR, DATA, ACC, DONE)
  - WAVE_PTR_W=5, SAMPLE_W=8, VOLUME_W=4, VOL_SHIFT=4
- One sub-module, wts_volume_mul: registered signed 8×unsigned 4 multiply and >>>4 with enable gating, instantiated once and shared across slots.
- Pointer bank and FSM stay in the top module.

## Test plan
- Reset, then tick with all volumes 0 and sram_q=0x7F: mix_valid at tick+16, mix_out=0. Check 5 sram_rd pulses with addresses 0x00,0x20,0x40,0x60,0x80.
- Channel 0 only enabled, vol=15, sram_q=0x7F → mix_out=119. With sram_q=0x80 → mix_out=-120.
- All 5 enabled, vol=15, sram_q=0x80 → mix_out=-600. With sram_q=0x7F → mix_out=595.
- step_req[2] pulsed 33 times → ptr[2]=1. Next frame address for ch2 is 0x41.
- Repeat with step_req[2] coincident with ch2 ADDR: the frame uses the old pointer and the following frame uses the new one.
- Second tick at tick+5 → overrun pulse, and first frame completes unchanged.
- reg_volume changed mid-frame: current frame uses the snapshot.
- Reset asserted mid-frame: no mix_valid, and all outputs return to reset values.
